// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, small output FIFO to
// decode, redirect flush with wrong-path response drop.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0]   fetch_pc;
  logic [31:0]   issued_pc;
  logic [31:0]   inst_q [BUF_DEPTH];
  logic [31:0]   pc_q   [BUF_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic req_fire;
  logic push;
  logic pop;
  logic has_slot;
  logic unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  assign out_valid = !reset && (count != '0);
  assign pop       = out_valid && out_ready;
  // A pop this cycle frees a slot for the request being issued now.
  assign has_slot  = (count != CW'(BUF_DEPTH)) || pop;
  assign req_fire  = imem_req_valid && imem_req_ready;
  assign push      = (state == S_WAIT) && imem_resp_valid
                     && !redirect_valid;

  assign imem_req_addr = fetch_pc;
  assign out_inst      = inst_q[head];
  assign out_pc        = pc_q[head];
  assign out_pc_plus4  = pc_q[head] + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_REQ: begin
        if (req_fire) begin
          state_nxt = redirect_valid ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          state_nxt = S_REQ;
        end else if (redirect_valid) begin
          state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_resp_valid) begin
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

  always_comb begin
    imem_req_valid = 1'b0;
    unique case (state)
      S_REQ:   imem_req_valid = has_slot && !reset;
      default: imem_req_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      issued_pc <= RESET_PC;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (req_fire) begin
        issued_pc <= fetch_pc;
      end
      if (redirect_valid) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          tail <= tail + PW'(1);
        end
        if (pop) begin
          head <= head + PW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      inst_q[tail] <= imem_resp_data;
      pc_q[tail]   <= issued_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances, one at RESET_PC 0 and one
// near the top of the address space to exercise wrap.
module tb_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5A5A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset = 1'b1;
  logic        a_redirect_valid = 1'b0;
  logic [31:0] a_redirect_pc = '0;
  logic        a_req_valid;
  logic        a_req_ready = 1'b1;
  logic [31:0] a_req_addr;
  logic        a_resp_valid;
  logic [31:0] a_resp_data;
  logic        a_out_valid;
  logic        a_out_ready = 1'b0;
  logic [31:0] a_out_inst;
  logic [31:0] a_out_pc;
  logic [31:0] a_out_pc_plus4;

  logic        b_reset = 1'b1;
  logic        b_redirect_valid = 1'b0;
  logic [31:0] b_redirect_pc = '0;
  logic        b_req_valid;
  logic        b_req_ready = 1'b0;
  logic [31:0] b_req_addr;
  logic        b_resp_valid;
  logic [31:0] b_resp_data;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic [31:0] b_out_inst;
  logic [31:0] b_out_pc;
  logic [31:0] b_out_pc_plus4;

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) u_a (
    .clk(clk), .reset(a_reset),
    .redirect_valid(a_redirect_valid), .redirect_pc(a_redirect_pc),
    .imem_req_valid(a_req_valid), .imem_req_ready(a_req_ready),
    .imem_req_addr(a_req_addr),
    .imem_resp_valid(a_resp_valid), .imem_resp_data(a_resp_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_inst(a_out_inst), .out_pc(a_out_pc),
    .out_pc_plus4(a_out_pc_plus4)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) u_b (
    .clk(clk), .reset(b_reset),
    .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
    .imem_req_valid(b_req_valid), .imem_req_ready(b_req_ready),
    .imem_req_addr(b_req_addr),
    .imem_resp_valid(b_resp_valid), .imem_resp_data(b_resp_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_inst(b_out_inst), .out_pc(b_out_pc),
    .out_pc_plus4(b_out_pc_plus4)
  );

  // Memory A: latency a_lat cycles; ignores requests while one is pending.
  int          a_lat = 1;
  logic        a_pend = 1'b0;
  int          a_cnt = 0;
  logic [31:0] a_paddr = '0;
  logic        a_mv = 1'b0;
  logic [31:0] a_md = '0;

  always @(posedge clk) begin
    a_mv <= 1'b0;
    if (a_pend) begin
      if (a_cnt <= 1) begin
        a_mv   <= 1'b1;
        a_md   <= a_paddr ^ K;
        a_pend <= 1'b0;
      end else begin
        a_cnt <= a_cnt - 1;
      end
    end else if (a_req_valid && a_req_ready) begin
      if (a_lat <= 1) begin
        a_mv <= 1'b1;
        a_md <= a_req_addr ^ K;
      end else begin
        a_pend  <= 1'b1;
        a_paddr <= a_req_addr;
        a_cnt   <= a_lat - 1;
      end
    end
  end
  assign a_resp_valid = a_mv;
  assign a_resp_data  = a_md;

  logic        b_mv = 1'b0;
  logic [31:0] b_md = '0;
  always @(posedge clk) begin
    b_mv <= 1'b0;
    if (b_req_valid && b_req_ready) begin
      b_mv <= 1'b1;
      b_md <= b_req_addr ^ K;
    end
  end
  assign b_resp_valid = b_mv;
  assign b_resp_data  = b_md;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] a_req_log[$];
  logic [31:0] a_opc_log[$];
  logic [31:0] a_oin_log[$];
  int          a_ocy_log[$];
  logic [31:0] b_req_log[$];
  logic [31:0] b_opc_log[$];
  logic [31:0] b_op4_log[$];

  always @(posedge clk) begin
    if (!a_reset) begin
      if (a_req_valid && a_req_ready) a_req_log.push_back(a_req_addr);
      if (a_out_valid && a_out_ready) begin
        a_opc_log.push_back(a_out_pc);
        a_oin_log.push_back(a_out_inst);
        a_ocy_log.push_back(cyc);
      end
    end
    if (!b_reset) begin
      if (b_req_valid && b_req_ready) b_req_log.push_back(b_req_addr);
      if (b_out_valid && b_out_ready) begin
        b_opc_log.push_back(b_out_pc);
        b_op4_log.push_back(b_out_pc_plus4);
      end
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int qci(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -1000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_do_reset();
    a_reset = 1'b1;
    a_redirect_valid = 1'b0;
    tick();
    tick();
    a_reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    a_reset = 1'b1;
    a_out_ready = 1'b0;
    a_req_ready = 1'b1;
    a_lat = 1;
    tick();
    n_checks++;
    if (a_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req_valid: got %b expected 0", a_req_valid);
    end
    n_checks++;
    if (a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid: got %b expected 0", a_out_valid);
    end
    tick();
    a_reset = 1'b0;
    #1;
    n_checks++;
    if (a_req_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_req: got %b expected 1", a_req_valid);
    end
    n_checks++;
    if (a_req_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_first_addr: got %h expected 0", a_req_addr);
    end
  endtask

  task automatic test_stall_full();
    repeat (10) tick();
    n_checks++;
    if (a_req_log.size() !== 2) begin
      n_fail++;
      $display("FAIL full_req_count: got %0d expected 2", a_req_log.size());
    end
    n_checks++;
    if (qat(a_req_log, 1) !== 32'h4) begin
      n_fail++;
      $display("FAIL full_req1: got %h expected 4", qat(a_req_log, 1));
    end
    n_checks++;
    if (a_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_req_valid: got %b expected 0", a_req_valid);
    end
    for (int r = 0; r < 2; r++) begin
      n_checks++;
      if (a_out_valid !== 1'b1 || a_out_pc !== 32'h0) begin
        n_fail++;
        $display("FAIL full_head_pc: got v=%b pc=%h expected v=1 pc=0",
                 a_out_valid, a_out_pc);
      end
      n_checks++;
      if (a_out_inst !== K) begin
        n_fail++;
        $display("FAIL full_head_inst: got %h expected %h", a_out_inst, K);
      end
      n_checks++;
      if (a_out_pc_plus4 !== 32'h4) begin
        n_fail++;
        $display("FAIL full_head_p4: got %h expected 4", a_out_pc_plus4);
      end
      repeat (3) tick();
    end
  endtask

  task automatic test_streaming();
    int s;
    s = a_opc_log.size();
    a_out_ready = 1'b1;
    repeat (14) tick();
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (qat(a_opc_log, s + i) !== 32'(i * 4)) begin
        n_fail++;
        $display("FAIL stream_pc[%0d]: got %h expected %h",
                 i, qat(a_opc_log, s + i), 32'(i * 4));
      end
      n_checks++;
      if (qat(a_oin_log, s + i) !== (32'(i * 4) ^ K)) begin
        n_fail++;
        $display("FAIL stream_inst[%0d]: got %h expected %h",
                 i, qat(a_oin_log, s + i), 32'(i * 4) ^ K);
      end
    end
    for (int i = 3; i < 6; i++) begin
      n_checks++;
      if (qci(a_ocy_log, s + i) - qci(a_ocy_log, s + i - 1) !== 2) begin
        n_fail++;
        $display("FAIL stream_gap[%0d]: got %0d expected 2", i,
                 qci(a_ocy_log, s + i) - qci(a_ocy_log, s + i - 1));
      end
    end
  endtask

  task automatic test_redirect_wait();
    int s;
    int so;
    int n;
    a_lat = 3;
    a_out_ready = 1'b1;
    a_do_reset();
    s = a_req_log.size();
    n = 0;
    while (a_req_log.size() < s + 3 && n < 100) begin
      tick();
      n++;
    end
    n_checks++;
    if (qat(a_req_log, s + 2) !== 32'h8) begin
      n_fail++;
      $display("FAIL rdw_prior_req: got %h expected 8", qat(a_req_log, s + 2));
    end
    so = a_opc_log.size();
    a_redirect_valid = 1'b1;
    a_redirect_pc = 32'h0040_0013;
    tick();
    a_redirect_valid = 1'b0;
    #1;
    n_checks++;
    if (a_req_valid !== 1'b0 || a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rdw_after: got req_v=%b out_v=%b expected 0 0",
               a_req_valid, a_out_valid);
    end
    n = 0;
    while (a_opc_log.size() <= so && n < 100) begin
      tick();
      n++;
    end
    n_checks++;
    if (qat(a_req_log, s + 3) !== 32'h0040_0010) begin
      n_fail++;
      $display("FAIL rdw_req: got %h expected 00400010", qat(a_req_log, s + 3));
    end
    n_checks++;
    if (qat(a_opc_log, so) !== 32'h0040_0010) begin
      n_fail++;
      $display("FAIL rdw_out_pc: got %h expected 00400010", qat(a_opc_log, so));
    end
    n_checks++;
    if (qat(a_oin_log, so) !== (32'h0040_0010 ^ K)) begin
      n_fail++;
      $display("FAIL rdw_out_inst: got %h expected %h",
               qat(a_oin_log, so), 32'h0040_0010 ^ K);
    end
  endtask

  task automatic test_redirect_resp();
    int s;
    int so;
    int n;
    a_lat = 1;
    s = a_req_log.size();
    n = 0;
    while (a_req_log.size() < s + 1 && n < 100) begin
      tick();
      n++;
    end
    so = a_opc_log.size();
    a_redirect_valid = 1'b1;
    a_redirect_pc = 32'h0000_0100;
    tick();
    a_redirect_valid = 1'b0;
    #1;
    n_checks++;
    if (a_req_valid !== 1'b1 || a_req_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL rdr_req: got v=%b addr=%h expected v=1 addr=100",
               a_req_valid, a_req_addr);
    end
    n_checks++;
    if (a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rdr_no_push: got out_valid=%b expected 0", a_out_valid);
    end
    n = 0;
    while (a_opc_log.size() <= so && n < 100) begin
      tick();
      n++;
    end
    n_checks++;
    if (qat(a_opc_log, so) !== 32'h100) begin
      n_fail++;
      $display("FAIL rdr_out_pc: got %h expected 100", qat(a_opc_log, so));
    end
    n_checks++;
    if (qat(a_oin_log, so) !== (32'h100 ^ K)) begin
      n_fail++;
      $display("FAIL rdr_out_inst: got %h expected %h",
               qat(a_oin_log, so), 32'h100 ^ K);
    end
  endtask

  task automatic test_reset_mid_wait();
    int s;
    int n;
    a_lat = 3;
    a_out_ready = 1'b0;
    a_do_reset();
    s = a_req_log.size();
    n = 0;
    while (a_req_log.size() < s + 2 && n < 100) begin
      tick();
      n++;
    end
    n_checks++;
    if (qat(a_req_log, s + 1) !== 32'h4 || a_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rmw_pre: got addr=%h out_v=%b expected addr=4 out_v=1",
               qat(a_req_log, s + 1), a_out_valid);
    end
    a_reset = 1'b1;
    tick();
    n_checks++;
    if (a_out_valid !== 1'b0 || a_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rmw_in_reset: got out_v=%b req_v=%b expected 0 0",
               a_out_valid, a_req_valid);
    end
    a_reset = 1'b0;
    #1;
    n_checks++;
    if (a_req_valid !== 1'b1 || a_req_addr !== 32'h0 || a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rmw_req: got v=%b addr=%h out_v=%b expected 1 0 0",
               a_req_valid, a_req_addr, a_out_valid);
    end
    n = 0;
    while (a_out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (a_out_valid !== 1'b1 || a_out_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL rmw_out_pc: got v=%b pc=%h expected v=1 pc=0",
               a_out_valid, a_out_pc);
    end
    n_checks++;
    if (a_out_inst !== 32'hA5A5_A5A1) begin
      n_fail++;
      $display("FAIL rmw_out_inst: got %h expected a5a5a5a1", a_out_inst);
    end
  endtask

  task automatic test_wrap_backpressure();
    logic        hold_v;
    logic [31:0] hold_a;
    int          holds;
    holds = 0;
    b_out_ready = 1'b1;
    b_req_ready = 1'b0;
    b_reset = 1'b1;
    tick();
    tick();
    b_reset = 1'b0;
    for (int i = 0; i < 24; i++) begin
      b_req_ready = (i % 3 == 2);
      #1;
      hold_v = b_req_valid && !b_req_ready;
      hold_a = b_req_addr;
      tick();
      if (hold_v) begin
        holds++;
        n_checks++;
        if (b_req_valid !== 1'b1 || b_req_addr !== hold_a) begin
          n_fail++;
          $display("FAIL wrap_hold: got v=%b addr=%h expected v=1 addr=%h",
                   b_req_valid, b_req_addr, hold_a);
        end
      end
    end
    n_checks++;
    if (holds < 3) begin
      n_fail++;
      $display("FAIL wrap_hold_seen: got %0d stalls expected >= 3", holds);
    end
    n_checks++;
    if (qat(b_req_log, 0) !== 32'hFFFF_FFF8 || qat(b_req_log, 1) !== 32'hFFFF_FFFC
        || qat(b_req_log, 2) !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_addrs: got %h %h %h expected fffffff8 fffffffc 0",
               qat(b_req_log, 0), qat(b_req_log, 1), qat(b_req_log, 2));
    end
    n_checks++;
    if (qat(b_opc_log, 1) !== 32'hFFFF_FFFC || qat(b_op4_log, 1) !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_p4: got pc=%h p4=%h expected fffffffc 0",
               qat(b_opc_log, 1), qat(b_op4_log, 1));
    end
    n_checks++;
    if (qat(b_opc_log, 2) !== 32'h0 || qat(b_op4_log, 2) !== 32'h4) begin
      n_fail++;
      $display("FAIL wrap_after: got pc=%h p4=%h expected 0 4",
               qat(b_opc_log, 2), qat(b_op4_log, 2));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stall_full();
    test_streaming();
    test_redirect_wait();
    test_redirect_resp();
    test_reset_mid_wait();
    test_wrap_backpressure();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
